// File: rtl/ssg_scan_ctrl_if.sv
// rtl/ssg_scan_ctrl_if.sv - digit write handshake between host logic and ssg_scan_ctrl
interface ssg_scan_ctrl_if;
  logic       wr_en;
  logic [1:0] wr_digit;
  logic [3:0] wr_data;
  logic       wr_dp;
  logic       wr_ack;

  modport master (
    output wr_en,
    output wr_digit,
    output wr_data,
    output wr_dp,
    input  wr_ack
  );

  modport slave (
    input  wr_en,
    input  wr_digit,
    input  wr_data,
    input  wr_dp,
    output wr_ack
  );
endinterface

// File: rtl/ssg_scan_ctrl.sv
// rtl/ssg_scan_ctrl.sv - 4-digit seven-segment scan scheduler with dead-time blanking
// SSG_LEADING_ZERO_BLANK_EN enables leading-zero suppression of digits 3..1.
module ssg_scan_ctrl #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  mclk,
  input  logic                  rst_n,
  input  logic                  en_i,
  ssg_scan_ctrl_if.slave        wr,
  output logic [3:0]            an_o,
  output logic [7:0]            ssg_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_BLANK = 2'd1,
    S_SCAN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0][3:0]   digit_q, digit_d;
  logic [3:0]        dp_q, dp_d;
  logic [3:0]        an_q, an_d;
  logic [7:0]        ssg_q, ssg_d;
  logic              ack_q;
  logic [3:0]        suppress_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // Output registers are fed from the post-write digit values so a write lands on the same edge.
  always_comb begin
    digit_d = digit_q;
    dp_d    = dp_q;
    if (wr.wr_en) begin
      digit_d[wr.wr_digit] = wr.wr_data;
      dp_d[wr.wr_digit]    = wr.wr_dp;
    end
  end

`ifdef SSG_LEADING_ZERO_BLANK_EN
  logic [3:1] zero_d;
  for (genvar i = 1; i < 4; i++) begin : g_zero
    assign zero_d[i] = (digit_d[i] == 4'h0) && !dp_d[i];
  end
  assign suppress_d = {zero_d[3], &zero_d[3:2], &zero_d[3:1], 1'b0};
`else
  assign suppress_d = 4'b0000;
`endif

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      digit_q <= '0;
      dp_q    <= 4'b0000;
      an_q    <= 4'b1111;
      ssg_q   <= 8'hFF;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      ssg_q   <= ssg_d;
      ack_q   <= wr.wr_en;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (!en_i) begin
      state_d = S_OFF;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = S_BLANK;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
        S_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = S_SCAN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_SCAN: begin
          if (cnt_q == SCAN_LAST) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = S_OFF;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A suppressed digit keeps its slot timing but stays dark.
  always_comb begin
    an_d  = 4'b1111;
    ssg_d = 8'hFF;
    if (state_d == S_SCAN && !suppress_d[idx_d]) begin
      an_d  = ~(4'b0001 << idx_d);
      ssg_d = {~dp_d[idx_d], hex7(digit_d[idx_d])};
    end
  end

  assign an_o      = an_q;
  assign ssg_o     = ssg_q;
  assign wr.wr_ack = ack_q;

endmodule

// File: tb/tb_ssg_scan_ctrl.sv
// tb/tb_ssg_scan_ctrl.sv - scoreboard bench for ssg_scan_ctrl (CLK_DIV=8, BLANK_CYCLES=2)
module tb_ssg_scan_ctrl;
  localparam int CLK_DIV      = 8;
  localparam int BLANK_CYCLES = 2;
  localparam int PERIOD       = CLK_DIV + BLANK_CYCLES;
  localparam logic [3:0] AN_OFF  = 4'hF;
  localparam logic [7:0] SSG_OFF = 8'hFF;

  logic       mclk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] an;
  logic [7:0] ssg;

  ssg_scan_ctrl_if wr_if();

  ssg_scan_ctrl #(
    .CLK_DIV     (CLK_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .mclk (mclk),
    .rst_n(rst_n),
    .en_i (en),
    .wr   (wr_if),
    .an_o (an),
    .ssg_o(ssg)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    int         tag;
    logic [3:0] an;
    logic [7:0] ssg;
  } exp_t;

  exp_t expq[$];
  int   ackq[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [7:0] ssg_p1 [4] = '{8'hF9, 8'hA4, 8'hB0, 8'h99};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge mclk) cyc++;

  // Monitor: expectations are tagged with the edge number after which they must hold.
  always @(negedge mclk) begin
    bit   exp_ack;
    exp_t e;
    exp_ack = (ackq.size() > 0) && (ackq[0] == cyc);
    if (exp_ack) void'(ackq.pop_front());
    check("wr_ack", 32'(wr_if.wr_ack), 32'(exp_ack));
    while (expq.size() > 0 && expq[0].tag < cyc) begin
      tests++;
      fails++;
      $display("FAIL display_missed: tag %0d not sampled, now cycle %0d", expq[0].tag, cyc);
      void'(expq.pop_front());
    end
    if (expq.size() > 0 && expq[0].tag == cyc) begin
      e = expq.pop_front();
      check("an", 32'(an), 32'(e.an));
      check("ssg", 32'(ssg), 32'(e.ssg));
    end
  end

  task automatic push_range(input int t0, input int t1, input logic [3:0] a, input logic [7:0] s);
    for (int t = t0; t <= t1; t++) expq.push_back('{tag: t, an: a, ssg: s});
  endtask

  task automatic push_slot(input int e, input int s, input logic [3:0] a, input logic [7:0] sg);
    int base;
    base = e + PERIOD * s;
    push_range(base + 1, base + BLANK_CYCLES, AN_OFF, SSG_OFF);
    push_range(base + BLANK_CYCLES + 1, base + BLANK_CYCLES + CLK_DIV, a, sg);
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic run_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic wr(input int d, input logic [3:0] v, input bit dp);
    wr_if.wr_en    = 1'b1;
    wr_if.wr_digit = d[1:0];
    wr_if.wr_data  = v;
    wr_if.wr_dp    = dp;
    ackq.push_back(cyc + 1);
    step();
    wr_if.wr_en = 1'b0;
  endtask

  initial begin
    int e;
    int r0;
    int r;
    logic [3:0] a5 [8];
    logic [7:0] s5 [8];

    rst_n          = 1'b1;
    en             = 1'b0;
    wr_if.wr_en    = 1'b0;
    wr_if.wr_digit = 2'd0;
    wr_if.wr_data  = 4'h0;
    wr_if.wr_dp    = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_an", 32'(an), 32'(AN_OFF));
    check("reset_ssg", 32'(ssg), 32'(SSG_OFF));
    check("reset_ack", 32'(wr_if.wr_ack), 32'(0));
    step();
    step();
    rst_n = 1'b1;

    // Load 1,2,3,4 while dark, then rotate twice.
    push_range(cyc + 1, cyc + 4, AN_OFF, SSG_OFF);
    wr(0, 4'h1, 1'b0);
    wr(1, 4'h2, 1'b0);
    wr(2, 4'h3, 1'b0);
    wr(3, 4'h4, 1'b0);
    e = cyc;
    for (int s = 0; s < 8; s++) push_slot(e, s, an_tab[s % 4], ssg_p1[s % 4]);

    // Mid-scan write, write on the BLANK->SCAN edge, digit 2 = A with dp, en drop and re-raise.
    push_range(e + 81,  e + 82,  AN_OFF,  SSG_OFF);
    push_range(e + 83,  e + 86,  4'b1110, 8'hF9);
    push_range(e + 87,  e + 90,  4'b1110, 8'h80);
    push_range(e + 91,  e + 92,  AN_OFF,  SSG_OFF);
    push_range(e + 93,  e + 100, 4'b1101, 8'h8E);
    push_range(e + 101, e + 102, AN_OFF,  SSG_OFF);
    push_range(e + 103, e + 110, 4'b1011, 8'h08);
    push_range(e + 111, e + 112, AN_OFF,  SSG_OFF);
    push_range(e + 113, e + 115, 4'b0111, 8'h99);
    push_range(e + 116, e + 120, AN_OFF,  SSG_OFF);
    push_range(e + 121, e + 124, 4'b1110, 8'h80);

    en = 1'b1;
    run_until(e + 84);
    wr(2, 4'hA, 1'b1);
    run_until(e + 86);
    wr(0, 4'h8, 1'b0);
    run_until(e + 92);
    wr(1, 4'hF, 1'b0);
    run_until(e + 115);
    en = 1'b0;
    run_until(e + 118);
    en = 1'b1;
    run_until(e + 124);

    // Asynchronous reset in the middle of the digit-0 slot.
    #6 rst_n = 1'b0;
    #1;
    check("async_rst_an", 32'(an), 32'(AN_OFF));
    check("async_rst_ssg", 32'(ssg), 32'(SSG_OFF));
    en = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Digits {3..0} = {0,0,5,0}, then dp on digit 3.
    r0 = cyc;
    push_range(r0 + 1, r0 + 1, AN_OFF, SSG_OFF);
    wr(1, 4'h5, 1'b0);
    r = cyc;
    a5 = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
    s5 = '{8'hC0, 8'h92, 8'hC0, 8'hC0, 8'hC0, 8'h92, 8'hC0, 8'h40};
`ifdef SSG_LEADING_ZERO_BLANK_EN
    a5[2] = AN_OFF;
    s5[2] = SSG_OFF;
    a5[3] = AN_OFF;
    s5[3] = SSG_OFF;
`endif
    for (int s = 0; s < 8; s++) push_slot(r, s, a5[s], s5[s]);
    en = 1'b1;
    run_until(r + 40);
    wr(3, 4'h0, 1'b1);
    run_until(r + 84);

    check("ack_queue_drained", 32'(ackq.size()), 32'(0));
    check("exp_queue_drained", 32'(expq.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
